mm_resp: RTL and testbench

- Bus response sequencer: the return path of the memory-mapped bus, opposite to the address decoder.
- Takes the decoded module index at request time, waits for that module's ready, steers its read data back to the CPU, and stalls the CPU until the access completes.
- Flags accesses to unmapped indices, and accesses whose module never answers, as bus errors.
- Sits between the CPU memory port and the peripheral set (rom, ram, uart, switches, leds, gpio, vga, plpid, timer, sseg, plpbot uarts).

---
 rtl/mm_resp_if.sv | 28 ++
 rtl/mm_resp.sv | 108 ++++++++++
 tb/tb_mm_resp.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mm_resp_if.sv
// mm_resp_if: CPU/peripheral return-path bundle for mm_resp.
// master = request/peripheral side, slave = the response sequencer.
interface mm_resp_if #(
  parameter int NMOD = 12
);
  logic              req;
  logic              we;
  logic [7:0]        mod;
  logic [NMOD-1:0]   slv_rdy;
  logic [32*NMOD-1:0] slv_rdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              cpu_done;
  logic              bus_err;
  logic [7:0]        err_mod;

  modport master (
    output req, we, mod, slv_rdy, slv_rdata,
    input  cpu_rdata, cpu_stall, cpu_done,
    input  bus_err, err_mod
  );

  modport slave (
    input  req, we, mod, slv_rdy, slv_rdata,
    output cpu_rdata, cpu_stall, cpu_done,
    output bus_err, err_mod
  );
endinterface

// File: rtl/mm_resp.sv
// mm_resp: bus response sequencer (ready wait, read-data return, errors).
// Define MM_RESP_WDT_EN to build the WAIT timeout watchdog.
module mm_resp #(
  parameter int NMOD    = 12,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input logic     clk,
  input logic     rst,
  mm_resp_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  if (NMOD < 1 || NMOD > 255 || TIMEOUT < 1 ||
      TIMEOUT >= (1 << TW)) begin : g_bad_cfg
    $error("mm_resp: bad NMOD/TIMEOUT/TW");
  end

  logic [1:0]  state;
  logic [7:0]  cur_mod;
  logic        cur_we;
  logic        sel_rdy;
  logic [31:0] sel_data;
  logic        accept;
  logic        unmapped;
  logic        in_wait;

  always_comb begin
    sel_rdy  = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NMOD; k++) begin
      if (cur_mod == 8'(k)) begin
        sel_rdy  = bus.slv_rdy[k];
        sel_data = bus.slv_rdata[32*k +: 32];
      end
    end
  end

  assign in_wait  = (state == WAIT);
  assign accept   = bus.req && !in_wait;
  assign unmapped = (bus.mod >= 8'(NMOD));

  assign bus.cpu_stall = rst && (bus.req || in_wait);
  assign bus.cpu_done  = (state == RESP);

`ifdef MM_RESP_WDT_EN
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] cnt;
  logic          wdt_hit;

  assign wdt_hit = (cnt == CNT_LAST);

  // Counter only advances while waiting; the exit at CNT_LAST stops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (in_wait && !sel_rdy && !wdt_hit) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic wdt_hit;
  assign wdt_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cur_mod       <= '0;
      cur_we        <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.bus_err   <= 1'b0;
      bus.err_mod   <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          cur_mod     <= bus.mod;
          cur_we      <= bus.we;
          bus.bus_err <= unmapped;
          if (unmapped) begin
            bus.err_mod   <= bus.mod;
            bus.cpu_rdata <= '0;
            state         <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        in_wait: begin
          // Ready wins over a timeout landing in the same cycle.
          if (sel_rdy) begin
            bus.cpu_rdata <= cur_we ? 32'h0 : sel_data;
            state         <= RESP;
          end else if (wdt_hit) begin
            bus.bus_err   <= 1'b1;
            bus.err_mod   <= cur_mod;
            bus.cpu_rdata <= '0;
            state         <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_resp.sv
// tb_mm_resp: table-driven + scoreboard bench for mm_resp.
// Timeout expectations follow MM_RESP_WDT_EN.
module tb_mm_resp;
  localparam int NMOD = 12;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  err_mod;
    int          lat;
  } exp_t;

  typedef struct {
    logic [7:0]  mod;
    logic        we;
    int          rdy_cyc;
    logic [31:0] data;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  vec_t vt[7];

  mm_resp_if #(.NMOD(NMOD)) bus ();

  mm_resp #(
    .NMOD   (NMOD),
    .TIMEOUT(255),
    .TW     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [7:0] m, input logic w,
                        input int rdy_cyc, input logic [31:0] d,
                        input exp_t e, input string nm);
    logic [NMOD-1:0] oh;
    exp_t got;
    bit   seen;
    bit   stall_ok;
    int   lat;
    sb.push_back(e);
    oh = '0;
    if (m < NMOD) oh[m] = 1'b1;
    bus.req = 1'b1;
    bus.mod = m;
    bus.we  = w;
    bus.slv_rdy = '0;
    for (int k = 0; k < NMOD; k++)
      bus.slv_rdata[32*k +: 32] = ~d;
    if (m < NMOD) bus.slv_rdata[32*m +: 32] = d;
    seen = 0;
    stall_ok = 1;
    lat = -1;
    @(negedge clk);
    if (bus.cpu_stall !== 1'b1) stall_ok = 0;
    nxt();
    bus.req = 1'b0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      if (rdy_cyc >= 0 && c >= rdy_cyc) bus.slv_rdy = oh;
      else bus.slv_rdy = ~oh;
      @(negedge clk);
      if (bus.cpu_stall !== (c < e.lat)) stall_ok = 0;
      if (bus.cpu_done === 1'b1) begin
        seen = 1;
        lat = c;
      end else begin
        nxt();
      end
    end
    if (!seen) begin
      check({nm, "_done_timeout"}, 32'(lat), 32'(e.lat));
      void'(sb.pop_front());
    end else if (sb.size() > 0) begin
      got = sb.pop_front();
      check({nm, "_rdata"}, bus.cpu_rdata, got.rdata);
      check({nm, "_err"}, 32'(bus.bus_err), 32'(got.err));
      check({nm, "_err_mod"}, 32'(bus.err_mod), 32'(got.err_mod));
      check({nm, "_latency"}, 32'(lat), 32'(got.lat));
    end
    check({nm, "_stall_profile"}, 32'(stall_ok), 32'd1);
    nxt();
    bus.slv_rdy = '0;
  endtask

  initial begin
    exp_t e;
    int   dn;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.req = 1'b1;
    bus.we  = 1'b0;
    bus.mod = 8'd5;
    bus.slv_rdy = '1;
    bus.slv_rdata = '1;

    vt[0] = '{8'd1,   1'b0, 1,  32'h12345678,
              '{32'h12345678, 1'b0, 8'd0,   2}};
    vt[1] = '{8'd12,  1'b0, 1,  32'hFFFFFFFF,
              '{32'h00000000, 1'b1, 8'd12,  1}};
    vt[2] = '{8'd0,   1'b1, 4,  32'hDEADBEEF,
              '{32'h00000000, 1'b0, 8'd12,  5}};
    vt[3] = '{8'd11,  1'b0, 2,  32'hCAFEF00D,
              '{32'hCAFEF00D, 1'b0, 8'd12,  3}};
    vt[4] = '{8'd255, 1'b1, 1,  32'h11111111,
              '{32'h00000000, 1'b1, 8'd255, 1}};
    vt[5] = '{8'd7,   1'b0, 1,  32'h00000001,
              '{32'h00000001, 1'b0, 8'd255, 2}};
    vt[6] = '{8'd13,  1'b0, 1,  32'h22222222,
              '{32'h00000000, 1'b1, 8'd13,  1}};

    @(negedge clk);
    check("rst_stall", 32'(bus.cpu_stall), 32'd0);
    check("rst_done", 32'(bus.cpu_done), 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    check("rst_err", 32'(bus.bus_err), 32'd0);
    check("rst_err_mod", 32'(bus.err_mod), 32'd0);
    nxt();
    bus.req = 1'b0;
    bus.slv_rdy = '0;
    nxt();
    rst = 1'b1;
    nxt();

    for (int i = 0; i < 7; i++)
      access(vt[i].mod, vt[i].we, vt[i].rdy_cyc, vt[i].data,
             vt[i].e, $sformatf("vec%0d", i));

`ifdef MM_RESP_WDT_EN
    e = '{32'h00000000, 1'b1, 8'd3, 256};
    access(8'd3, 1'b0, -1, 32'h13579BDF, e, "timeout");
    e = '{32'hA5A5A5A5, 1'b0, 8'd3, 256};
`else
    e = '{32'h13579BDF, 1'b0, 8'd13, 301};
    access(8'd3, 1'b0, 300, 32'h13579BDF, e, "hold");
    e = '{32'hA5A5A5A5, 1'b0, 8'd13, 256};
`endif
    access(8'd3, 1'b0, 255, 32'hA5A5A5A5, e, "race");

    bus.req = 1'b1;
    bus.mod = 8'd12;
    bus.we  = 1'b0;
    bus.slv_rdy = '0;
    bus.slv_rdata[31:0] = 32'h0BADF00D;
    nxt();
    bus.mod = 8'd0;
    @(negedge clk);
    check("b2b_err_done", 32'(bus.cpu_done), 32'd1);
    check("b2b_err_flag", 32'(bus.bus_err), 32'd1);
    check("b2b_err_mod", 32'(bus.err_mod), 32'd12);
    check("b2b_stall", 32'(bus.cpu_stall), 32'd1);
    nxt();
    bus.req = 1'b0;
    bus.slv_rdy = 12'h001;
    @(negedge clk);
    check("b2b_wait_done", 32'(bus.cpu_done), 32'd0);
    check("b2b_err_clr", 32'(bus.bus_err), 32'd0);
    check("b2b_wait_stall", 32'(bus.cpu_stall), 32'd1);
    nxt();
    @(negedge clk);
    check("b2b_done", 32'(bus.cpu_done), 32'd1);
    check("b2b_rdata", bus.cpu_rdata, 32'h0BADF00D);
    check("b2b_err_end", 32'(bus.bus_err), 32'd0);
    check("b2b_err_mod_hold", 32'(bus.err_mod), 32'd12);
    nxt();
    bus.slv_rdy = '0;
    nxt();

    bus.req = 1'b1;
    bus.mod = 8'd2;
    for (int k = 0; k < NMOD; k++)
      bus.slv_rdata[32*k +: 32] = 32'h5555AAAA;
    nxt();
    bus.req = 1'b0;
    @(negedge clk);
    check("mid_wait_stall", 32'(bus.cpu_stall), 32'd1);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_stall", 32'(bus.cpu_stall), 32'd0);
    check("mid_rst_done", 32'(bus.cpu_done), 32'd0);
    check("mid_rst_rdata", bus.cpu_rdata, 32'd0);
    check("mid_rst_err", 32'(bus.bus_err), 32'd0);
    check("mid_rst_err_mod", 32'(bus.err_mod), 32'd0);
    nxt();
    rst = 1'b1;
    nxt();
    bus.slv_rdy = 12'h004;
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.cpu_done === 1'b1 || bus.cpu_stall === 1'b1) dn++;
      nxt();
    end
    check("late_rdy_ignored", 32'(dn), 32'd0);
    check("late_rdy_rdata", bus.cpu_rdata, 32'd0);
    bus.slv_rdy = '0;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
